// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// One operation is in flight at a time: grant in IDLE, sample the ALU in EXEC, hold the response in RESP.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req0_op,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_first,
    output logic [WIDTH-1:0] alu_second,
    output logic [3:0]       alu_select,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             busy,
    output logic [1:0]       state_dbg,
    output logic             ptr_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    state_t           state;
    logic             ptr;
    logic             grant;
    logic             err;

    logic             any_req;
    logic             gnt_sel;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_legal;
    logic             rsp_done;

    // Handshakes: a request transfers in the cycle where reqN_valid and reqN_ready are both high
    // (ready is a combinational pulse in IDLE only); a response transfers when rspN_valid and rspN_ready are both high.
    always_comb begin
        gnt_sel = 1'b0;
        if (req0_valid && req1_valid)
            gnt_sel = ptr;
        else
            gnt_sel = req1_valid;
    end

    assign any_req   = req0_valid || req1_valid;
    assign sel_op    = gnt_sel ? req1_op : req0_op;
    assign sel_a     = gnt_sel ? req1_a  : req0_a;
    assign sel_b     = gnt_sel ? req1_b  : req0_b;
    assign sel_legal = (sel_op == OP_AND) || (sel_op == OP_OR) || (sel_op == OP_ADD) ||
                       (sel_op == OP_SUB) || (sel_op == OP_SLT);

    assign req0_ready = rst_n && (state == IDLE) && any_req && !gnt_sel;
    assign req1_ready = rst_n && (state == IDLE) && any_req &&  gnt_sel;

    assign rsp0_valid = (state == RESP) && !grant;
    assign rsp1_valid = (state == RESP) &&  grant;
    assign rsp_done   = grant ? rsp1_ready : rsp0_ready;

    assign busy      = (state != IDLE);
    assign state_dbg = state;
    assign ptr_dbg   = ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            grant      <= 1'b0;
            err        <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            alu_first  <= '0;
            alu_second <= '0;
            alu_select <= OP_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= gnt_sel;
                        alu_first  <= sel_a;
                        alu_second <= sel_b;
                        // Illegal codes still drive a harmless ADD so the ALU inputs stay defined.
                        alu_select <= sel_legal ? sel_op : OP_ADD;
                        err        <= !sel_legal;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (err) begin
                        rsp_data <= '0;
                        rsp_zero <= 1'b0;
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_data <= alu_out;
                        rsp_zero <= alu_zero;
                        rsp_err  <= 1'b0;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        ptr   <= ~grant;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a table of single transactions plus hand-written
// sequences for round-robin, response back-pressure and reset during EXEC.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero, rsp_err;
    logic [31:0] alu_first, alu_second;
    logic [3:0]  alu_select;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        busy;
    logic [1:0]  state_dbg;
    logic        ptr_dbg;

    int n_cmp;
    int n_fail;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_first(alu_first), .alu_second(alu_second), .alu_select(alu_select),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .busy(busy), .state_dbg(state_dbg), .ptr_dbg(ptr_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU the block drives; zero flag compares the operands.
    always_comb begin
        case (alu_select)
            4'b0000: alu_out = alu_first & alu_second;
            4'b0001: alu_out = alu_first | alu_second;
            4'b0010: alu_out = alu_first + alu_second;
            4'b0110: alu_out = alu_first - alu_second;
            4'b0111: alu_out = {31'b0, ($signed(alu_first) < $signed(alu_second))};
            default: alu_out = alu_first + alu_second;
        endcase
        alu_zero = (alu_first == alu_second);
    end

    typedef struct {
        logic        who;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_zero;
        logic        exp_err;
        logic [3:0]  exp_sel;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // driver: one full transaction, entered and left just after a rising edge in IDLE
    task automatic run_vec(input int idx, input vec_t v);
        if (v.who) begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end
        @(negedge clk);
        chk1($sformatf("v%0d req0_ready", idx), req0_ready, !v.who);
        chk1($sformatf("v%0d req1_ready", idx), req1_ready, v.who);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk1($sformatf("v%0d busy", idx), busy, 1'b1);
        chk1($sformatf("v%0d early rsp", idx), rsp0_valid | rsp1_valid, 1'b0);
        chk($sformatf("v%0d alu_select", idx), {28'b0, alu_select}, {28'b0, v.exp_sel});
        @(posedge clk); #1;
        @(negedge clk);
        chk1($sformatf("v%0d rsp0_valid", idx), rsp0_valid, !v.who);
        chk1($sformatf("v%0d rsp1_valid", idx), rsp1_valid, v.who);
        chk($sformatf("v%0d rsp_data", idx), rsp_data, v.exp_data);
        chk1($sformatf("v%0d rsp_zero", idx), rsp_zero, v.exp_zero);
        chk1($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        //           who   op       a             b             data          z     e     sel
        vecs[0]  = '{1'b0, 4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 4'b0010};
        vecs[1]  = '{1'b1, 4'b0110, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 4'b0110};
        vecs[2]  = '{1'b1, 4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, 4'b0110};
        vecs[3]  = '{1'b0, 4'b1100, 32'd1,        32'd2,        32'd0,        1'b0, 1'b1, 4'b0010};
        vecs[4]  = '{1'b0, 4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 4'b0000};
        vecs[5]  = '{1'b1, 4'b0001, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0, 4'b0001};
        vecs[6]  = '{1'b0, 4'b0111, 32'd3,        32'd5,        32'd1,        1'b0, 1'b0, 4'b0111};
        vecs[7]  = '{1'b1, 4'b0111, 32'd5,        32'd3,        32'd0,        1'b0, 1'b0, 4'b0111};
        vecs[8]  = '{1'b0, 4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 4'b0010};
        vecs[9]  = '{1'b1, 4'b0000, 32'h0000000A, 32'h0000000A, 32'h0000000A, 1'b1, 1'b0, 4'b0000};
        vecs[10] = '{1'b0, 4'b0011, 32'd4,        32'd4,        32'd0,        1'b0, 1'b1, 4'b0010};

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_op = 4'b0010; req1_op = 4'b0010;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("reset req0_ready", req0_ready, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk1("reset rsp_zero", rsp_zero, 1'b0);
        chk1("reset rsp_err", rsp_err, 1'b0);
        chk("reset alu_first", alu_first, 32'd0);
        chk("reset alu_second", alu_second, 32'd0);
        chk("reset alu_select", {28'b0, alu_select}, 32'h2);
        chk1("reset ptr", ptr_dbg, 1'b0);
        chk("reset state", {30'b0, state_dbg}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req0_valid = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // round-robin with both requesters permanently valid
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd2;
        req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd3; req1_b = 32'd4;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk1($sformatf("rr c%0d req0_ready", k), req0_ready, (k % 3 == 0) && ((k / 3) % 2 == 0));
            chk1($sformatf("rr c%0d req1_ready", k), req1_ready, (k % 3 == 0) && ((k / 3) % 2 == 1));
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // response back-pressure while the other requester waits
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd20; req0_b = 32'd22;
        req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd1;  req1_b = 32'd1;
        @(negedge clk);
        chk1("bp req0_ready", req0_ready, 1'b1);
        chk1("bp req1_ready T", req1_ready, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk1("bp req1_ready T+1", req1_ready, 1'b0);
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1($sformatf("bp hold%0d rsp0_valid", k), rsp0_valid, 1'b1);
            chk1($sformatf("bp hold%0d rsp1_valid", k), rsp1_valid, 1'b0);
            chk($sformatf("bp hold%0d rsp_data", k), rsp_data, 32'd42);
            chk1($sformatf("bp hold%0d req1_ready", k), req1_ready, 1'b0);
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk1("bp handshake rsp0_valid", rsp0_valid, 1'b1);
        chk1("bp handshake req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("bp req1 accepted", req1_ready, 1'b1);
        chk1("bp idle busy", busy, 1'b0);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk1("bp rsp1_valid", rsp1_valid, 1'b1);
        chk("bp rsp1 data", rsp_data, 32'd2);
        chk1("bp rsp1 zero", rsp_zero, 1'b1);
        @(posedge clk); #1;

        // reset pulse while an operation sits in EXEC
        run_vec(100, vecs[0]);
        @(negedge clk);
        chk1("rx ptr before", ptr_dbg, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd5; req0_b = 32'd7;
        @(negedge clk);
        chk1("rx req0_ready", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rx in EXEC", {30'b0, state_dbg}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rx busy", busy, 1'b0);
        chk1("rx rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
        chk1("rx ptr", ptr_dbg, 1'b0);
        chk("rx rsp_data", rsp_data, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk1($sformatf("rx after%0d rsp_valid", k), rsp0_valid | rsp1_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1, requester N presents an operation.
REQ-005 The block SHALL have ports req0_ready / req1_ready, output, 1, a one-cycle pulse marking acceptance of requester N's operation.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, WIDTH, the operands.
REQ-007 The block SHALL have ports req0_op / req1_op, input, 4, the ALU select code.
REQ-008 The block SHALL have ports rsp0_valid / rsp1_valid, output, 1, a result is held for requester N.
REQ-009 The block SHALL have ports rsp0_ready / rsp1_ready, input, 1, requester N consumes its result.
REQ-010 The block SHALL have shared ports rsp_data (output, WIDTH), rsp_zero (output, 1) and rsp_err (output, 1), qualified by rsp0_valid or rsp1_valid.
REQ-011 The block SHALL have ports alu_first, alu_second (output, WIDTH) and alu_select (output, 4), which drive the shared ALU.
REQ-012 The block SHALL have ports alu_out (input, WIDTH) and alu_zero (input, 1), the combinational ALU results.
REQ-013 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, EXEC and RESP.
REQ-015 In IDLE, if any reqN_valid is high, the block SHALL grant one requester, pulse its reqN_ready, capture a, b, op and the grant index, and go to EXEC.
REQ-016 Arbitration SHALL be round-robin with a 1-bit pointer, reset value 0: when both requesters are valid, the requester equal to the pointer wins; when only one is valid, that requester wins.
REQ-017 The pointer SHALL be set to the opposite of the granted index on the RESP->IDLE transition.
REQ-018 alu_first, alu_second and alu_select SHALL be registered, loaded at grant from the captured a, b and op, and held constant until the next grant.
REQ-019 Legal op codes SHALL be 0000 (AND), 0001 (OR), 0010 (ADD), 0110 (SUB) and 0111 (SLT); all other codes are illegal.
REQ-020 On an illegal op, the block SHALL load alu_select with 0010 and set an internal err flag.
REQ-021 In EXEC, the block SHALL register rsp_data = alu_out and rsp_zero = alu_zero, or rsp_data = 0, rsp_zero = 0 and rsp_err = 1 if err is set, and then go to RESP.
REQ-022 rsp_zero SHALL reproduce alu_zero unchanged, meaning first == second, and SHALL NOT be recomputed from the result.
REQ-023 In RESP, the block SHALL hold rspN_valid high for the granted N only, with rsp_data, rsp_zero and rsp_err stable.
REQ-024 In RESP, the block SHALL go to IDLE on the cycle in which rspN_ready is high; rspN_ready for the non-granted N SHALL be ignored.
REQ-025 Latency SHALL be: accept in cycle T, rspN_valid first high in cycle T+2; the next accept is no earlier than the cycle after the response handshake, giving a minimum period of 3 cycles.
REQ-026 reqN_ready SHALL never be high outside IDLE, and at most one reqN_ready SHALL be high in any cycle.
REQ-027 A requester that drops reqN_valid before acceptance SHALL lose nothing, since no partial capture occurs.
REQ-028 Overflow SHALL be ignored; ADD and SUB wrap modulo 2^WIDTH.

Reset
REQ-029 While rst_n is low at a clk edge, the block SHALL set the state to IDLE, the pointer to 0 and err to 0.
REQ-030 While rst_n is low at a clk edge, the block SHALL drive all reqN_ready, rspN_valid and busy to 0.
REQ-031 While rst_n is low at a clk edge, the block SHALL set rsp_data, rsp_zero, rsp_err, alu_first and alu_second to 0 and alu_select to 0010.
REQ-032 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is delivered after reset.

Verification
REQ-033 The bench SHALL drive req0 with ADD, a=5, b=7 -> req0_ready at T, rsp0_valid at T+2, rsp_data=12, rsp_zero=0, rsp_err=0.
REQ-034 The bench SHALL hold req0 and req1 valid together from reset with rsp ready tied high -> grants alternate 0,1,0,1 and each accept is 3 cycles apart.
REQ-035 The bench SHALL drive req1 with SUB, a=9, b=9 -> rsp1 gives rsp_data=0, rsp_zero=1; SUB with a=3, b=5 -> rsp_data=0xFFFFFFFE, rsp_zero=0.
REQ-036 The bench SHALL drive req0 with op=1100 -> alu_select reads 0010 and rsp0 gives rsp_err=1, rsp_data=0.
REQ-037 The bench SHALL hold rsp0_ready low for 4 cycles while req1 is valid -> rsp_data stays stable, req1_ready stays 0, and req1 is accepted the cycle after rsp0_ready rises.
REQ-038 The bench SHALL pull rst_n low for one cycle during EXEC -> the next cycle shows busy=0, no rspN_valid, and pointer 0.
